// File: rtl/ram_mp_pkg.sv
// ram_mp_pkg: shared types and helpers for the multi-read-port RAM.
package ram_mp_pkg;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    function automatic logic par_f(input logic [63:0] d);
        return ^d;
    endfunction
    function automatic int aofs(input int i, input int aw);
        return i * aw;
    endfunction
    function automatic int dofs(input int i, input int dw);
        return i * dw;
    endfunction
endpackage

// File: rtl/ram_mp_clear_fsm.sv
// ram_mp_clear_fsm: walks every implemented word after reset or clr_req so the array reads as zero.
module ram_mp_clear_fsm
    import ram_mp_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 4092
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_t st;
    logic [AW-1:0] ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= ST_CLEAR;
            ptr  <= '0;
            busy <= 1'b1;
        end else if (st == ST_CLEAR) begin
            if (ptr == LAST) begin
                st   <= ST_IDLE;
                busy <= 1'b0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end else if (clr_req) begin
            st   <= ST_CLEAR;
            ptr  <= '0;
            busy <= 1'b1;
        end
    end
    assign clr_we   = st == ST_CLEAR;
    assign clr_addr = ptr;
endmodule

// File: rtl/ram_mp_sync.sv
// ram_mp_sync: synchronous NRD-read / 1-write RAM with hardware clear.
// Define RAM_MP_PARITY_EN to store an even-parity bit per word and report rd_perr.
module ram_mp_sync
    import ram_mp_pkg::*;
#(
    parameter int DW          = 16,
    parameter int AW          = 12,
    parameter int DEPTH       = 4092,
    parameter int NRD         = 4,
    parameter int RD_LAT      = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_valid,
    output logic [NRD-1:0]    rd_perr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data
);
`ifdef RAM_MP_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] wr_word;
    logic          wr_ok;
    ram_mp_clear_fsm #(.AW(AW), .DEPTH(DEPTH)) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );
`ifdef RAM_MP_PARITY_EN
    assign wr_word = {par_f(64'(wr_data)), wr_data};
`else
    assign wr_word = wr_data;
`endif
    assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_X);
    // The clear sequencer owns the write port while busy.
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wr_ok)
            mem[wr_addr] <= wr_word;
    end
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          acc, inr, hit, pe;
        logic [MW-1:0] w;
        logic [DW-1:0] d1;
        logic          v1, p1;
        assign a   = rd_addr[aofs(i, AW) +: AW];
        assign acc = rd_en[i] && !busy;
        assign inr = {1'b0, a} < DEPTH_X;
        assign hit = WRITE_FIRST != 0 && wr_ok && wr_addr == a;
        assign w   = hit ? wr_word : mem[a];
`ifdef RAM_MP_PARITY_EN
        assign pe = par_f(64'(w[DW-1:0])) != w[MW-1];
`else
        assign pe = 1'b0;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d1 <= '0;
                v1 <= 1'b0;
                p1 <= 1'b0;
            end else begin
                v1 <= acc;
                p1 <= acc && inr && pe;
                if (acc)
                    d1 <= inr ? w[DW-1:0] : '0;
            end
        end
        if (RD_LAT == 2) begin : g_l2
            logic [DW-1:0] d2;
            logic          v2, p2;
            // Second stage runs regardless of busy so in-flight reads drain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                    p2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    p2 <= p1;
                    if (v1)
                        d2 <= d1;
                end
            end
            assign rd_data[dofs(i, DW) +: DW] = d2;
            assign rd_valid[i] = v2;
            assign rd_perr[i]  = p2;
        end else begin : g_l1
            assign rd_data[dofs(i, DW) +: DW] = d1;
            assign rd_valid[i] = v1;
            assign rd_perr[i]  = p1;
        end
    end
endmodule
